// File: rtl/debouncer_top.sv
`timescale 1ns/100ps
// debouncer_top: N-stage synchronizer -> stability counter -> 4-state FSM -> registered clean level.
// Build option DEBOUNCE_EDGE_PULSE_EN adds registered one-cycle rise_pulse / fall_pulse outputs.
module debouncer_top #(
  parameter int NUM_STAGES          = 2,
  parameter int COUNTER_FINAL_VALUE = 49,
  parameter int COUNTER_WIDTH       = $clog2(COUNTER_FINAL_VALUE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy_in,
  output logic debouncer_out
`ifdef DEBOUNCE_EDGE_PULSE_EN
  ,
  output logic rise_pulse,
  output logic fall_pulse
`endif
);

  localparam logic [1:0] STABLE_LOW  = 2'b00;
  localparam logic [1:0] WAIT_HIGH   = 2'b01;
  localparam logic [1:0] STABLE_HIGH = 2'b10;
  localparam logic [1:0] WAIT_LOW    = 2'b11;

  localparam logic [COUNTER_WIDTH-1:0] C_FINAL = COUNTER_WIDTH'(COUNTER_FINAL_VALUE);

  logic [NUM_STAGES-1:0]    r_sync;
  logic [1:0]               r_state;
  logic [COUNTER_WIDTH-1:0] r_count;
  logic                     r_out;

  logic                     w_sync_in;
  logic [1:0]               w_state_nxt;
  logic [COUNTER_WIDTH-1:0] w_count_nxt;
  logic                     w_out_nxt;

  assign w_sync_in = r_sync[NUM_STAGES-1];

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[NUM_STAGES-2:0], noisy_in};
    end
  end

  always_comb begin
    // NOTE: defaults first so no branch can leave a latch behind.
    w_state_nxt = r_state;
    w_count_nxt = '0;
    w_out_nxt   = r_out;
    case (r_state)
      STABLE_LOW: begin
        w_out_nxt = 1'b0;
        if (w_sync_in) w_state_nxt = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        w_out_nxt = 1'b0;
        if (!w_sync_in) begin
          w_state_nxt = STABLE_LOW;
        end else if (r_count == C_FINAL) begin
          w_state_nxt = STABLE_HIGH;
          w_out_nxt   = 1'b1;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      STABLE_HIGH: begin
        w_out_nxt = 1'b1;
        if (!w_sync_in) w_state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        w_out_nxt = 1'b1;
        if (w_sync_in) begin
          w_state_nxt = STABLE_HIGH;
        end else if (r_count == C_FINAL) begin
          w_state_nxt = STABLE_LOW;
          w_out_nxt   = 1'b0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LOW;
        w_out_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STABLE_LOW;
      r_count <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign debouncer_out = r_out;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic r_rise;
  logic r_fall;

  // Pulses land in the same cycle the registered level changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_out_nxt & ~r_out;
      r_fall <= ~w_out_nxt & r_out;
    end
  end

  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
`endif

endmodule

// File: tb/tb_debouncer_top.sv
`timescale 1ns/100ps
// Self-checking bench for debouncer_top: a run-length reference model fills a scoreboard
// each clock, scenario tasks pop and compare at the falling edge.
module tb_debouncer_top;

  localparam int NUM_STAGES = 2;
  localparam int FINAL      = 49;
  localparam int LATENCY    = NUM_STAGES + FINAL + 1;

  typedef struct packed {
    logic out;
    logic rise;
    logic fall;
  } exp_t;

  logic clk;
  logic rst;
  logic noisy_in;
  logic debouncer_out;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_pulse;
  logic fall_pulse;
`endif

  int tests_run;
  int tests_failed;

  exp_t exp_q[$];
  logic hist[$];
  logic m_out;
  logic m_s;
  int   m_run;
  exp_t m_x;

  debouncer_top #(
    .NUM_STAGES(NUM_STAGES),
    .COUNTER_FINAL_VALUE(FINAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .noisy_in(noisy_in),
    .debouncer_out(debouncer_out)
`ifdef DEBOUNCE_EDGE_PULSE_EN
    ,
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the output flips to a new level once the synchronized input has
  // shown that level on FINAL+2 consecutive samples (entry sample + FINAL+1 waits).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      hist.delete();
      for (int i = 0; i < NUM_STAGES; i++) hist.push_back(1'b0);
      m_out = 1'b0;
      m_run = 0;
    end else begin
      m_s = hist.pop_front();
      hist.push_back(noisy_in);
      m_x = '0;
      if (m_s !== m_out) begin
        m_run++;
        if (m_run == FINAL + 2) begin
          m_x.rise = m_s;
          m_x.fall = ~m_s;
          m_out    = m_s;
          m_run    = 0;
        end
      end else begin
        m_run = 0;
      end
      m_x.out = m_out;
`ifndef DEBOUNCE_EDGE_PULSE_EN
      m_x.rise = 1'b0;
      m_x.fall = 1'b0;
`endif
      exp_q.push_back(m_x);
    end
  end

  function automatic exp_t observe();
    exp_t o;
    o.out = debouncer_out;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    o.rise = rise_pulse;
    o.fall = fall_pulse;
`else
    o.rise = 1'b0;
    o.fall = 1'b0;
`endif
    return o;
  endfunction

  task automatic step(output exp_t e, output bit ok);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      e  = '0;
      ok = 1'b0;
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // 11 toggles at 1.6 ns, 5 at 5 ns, 4 at 10 ns, then settle; no change lands on a rising edge.
  task automatic run_burst(input logic final_val, output realtime t_last);
    #0.3 noisy_in = ~noisy_in;
    for (int i = 1; i < 11; i++) begin
      #1.6 noisy_in = ~noisy_in;
    end
    for (int i = 0; i < 5; i++) begin
      #5 noisy_in = ~noisy_in;
    end
    for (int i = 0; i < 4; i++) begin
      #10 noisy_in = ~noisy_in;
    end
    #10 noisy_in = final_val;
    t_last = $realtime;
  endtask

  task automatic test_reset();
    exp_t e;
    bit   ok;
    rst      = 1'b1;
    noisy_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (observe() !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_level: got %b required 000", observe());
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(e, ok);
      tests_run++;
      if (!ok || observe() !== e) begin
        tests_failed++;
        $display("FAIL reset_idle[%0d]: got %b required %b (entry %0d)", c, observe(), e, ok);
      end
    end
  endtask

  // Shared driver for the four burst scenarios; expect_change selects the latency check.
  task automatic burst_and_hold(input string name, input logic final_val, input bit expect_change);
    exp_t    e;
    bit      ok;
    realtime t_last;
    bit      seen;
    longint  lat;
    longint  tl;
    longint  cap;
    int      off_level;
    logic    start_level;
    start_level = expect_change ? ~final_val : final_val;
    seen        = 1'b0;
    lat         = 0;
    off_level   = 0;
    fork
      run_burst(final_val, t_last);
      for (int c = 0; c < 12; c++) begin
        step(e, ok);
        tests_run++;
        if (!ok || observe() !== e) begin
          tests_failed++;
          $display("FAIL %s_burst[%0d]: got %b required %b (entry %0d)", name, c, observe(), e, ok);
        end
        if (debouncer_out !== start_level) off_level++;
      end
    join
    for (int c = 0; c < 100; c++) begin
      step(e, ok);
      tests_run++;
      if (!ok || observe() !== e) begin
        tests_failed++;
        $display("FAIL %s_hold[%0d]: got %b required %b (entry %0d)", name, c, observe(), e, ok);
      end
      if (expect_change && !seen && debouncer_out === final_val) begin
        seen = 1'b1;
        tl   = longint'(t_last * 10.0);
        cap  = ((tl - 50) / 100) * 100 + 150;
        lat  = (longint'($realtime * 10.0) - 50 - cap) / 100;
      end
      if (!expect_change && debouncer_out !== start_level) off_level++;
    end
    if (expect_change) begin
      tests_run++;
      if (!seen || lat != LATENCY) begin
        tests_failed++;
        $display("FAIL %s_latency: got seen=%0d cycles=%0d required cycles=%0d", name, seen, lat, LATENCY);
      end
    end else begin
      tests_run++;
      if (off_level != 0) begin
        tests_failed++;
        $display("FAIL %s_stays: got %0d cycles off level required 0", name, off_level);
      end
    end
    tests_run++;
    if (debouncer_out !== final_val) begin
      tests_failed++;
      $display("FAIL %s_final: got %b required %b", name, debouncer_out, final_val);
    end
  endtask

  task automatic test_noisy_rise();
    burst_and_hold("noisy_rise", 1'b1, 1'b1);
  endtask

  task automatic test_glitch_high();
    burst_and_hold("glitch_high", 1'b1, 1'b0);
  endtask

  task automatic test_noisy_fall();
    burst_and_hold("noisy_fall", 1'b0, 1'b1);
  endtask

  task automatic test_glitch_low();
    burst_and_hold("glitch_low", 1'b0, 1'b0);
  endtask

  // One cycle short of the stability requirement must leave the output untouched.
  task automatic test_boundary_hold();
    exp_t e;
    bit   ok;
    int   highs;
    highs    = 0;
    noisy_in = 1'b1;
    for (int c = 0; c < FINAL + 1 + 60; c++) begin
      if (c == FINAL + 1) noisy_in = 1'b0;
      step(e, ok);
      tests_run++;
      if (!ok || observe() !== e) begin
        tests_failed++;
        $display("FAIL boundary[%0d]: got %b required %b (entry %0d)", c, observe(), e, ok);
      end
      if (debouncer_out !== 1'b0) highs++;
    end
    tests_run++;
    if (highs != 0) begin
      tests_failed++;
      $display("FAIL boundary_no_change: got %0d high cycles required 0", highs);
    end
  endtask

  task automatic test_edge_pulse();
    exp_t e;
    bit   ok;
    int   changes;
    int   rises;
    int   falls;
    logic prev;
    for (int dir = 0; dir < 2; dir++) begin
      changes  = 0;
      rises    = 0;
      falls    = 0;
      prev     = debouncer_out;
      noisy_in = (dir == 0);
      for (int c = 0; c < 80; c++) begin
        step(e, ok);
        tests_run++;
        if (!ok || observe() !== e) begin
          tests_failed++;
          $display("FAIL edge_pulse_%0d[%0d]: got %b required %b (entry %0d)", dir, c, observe(), e, ok);
        end
        if (debouncer_out !== prev) changes++;
        prev = debouncer_out;
`ifdef DEBOUNCE_EDGE_PULSE_EN
        if (rise_pulse === 1'b1) rises++;
        if (fall_pulse === 1'b1) falls++;
`endif
      end
      tests_run++;
      if (changes != 1 || debouncer_out !== (dir == 0)) begin
        tests_failed++;
        $display("FAIL edge_level_%0d: got %0d changes level %b required 1 change", dir, changes, debouncer_out);
      end
`ifdef DEBOUNCE_EDGE_PULSE_EN
      tests_run++;
      if (rises != (dir == 0 ? 1 : 0) || falls != (dir == 0 ? 0 : 1)) begin
        tests_failed++;
        $display("FAIL edge_pulse_count_%0d: got rise=%0d fall=%0d required rise=%0d fall=%0d",
                 dir, rises, falls, (dir == 0 ? 1 : 0), (dir == 0 ? 0 : 1));
      end
`endif
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    bit   ok;
    noisy_in = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step(e, ok);
      tests_run++;
      if (!ok || observe() !== e) begin
        tests_failed++;
        $display("FAIL midrst_rise[%0d]: got %b required %b (entry %0d)", c, observe(), e, ok);
      end
    end
    noisy_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(e, ok);
      tests_run++;
      if (!ok || observe() !== e || debouncer_out !== 1'b1) begin
        tests_failed++;
        $display("FAIL midrst_wait[%0d]: got %b required %b (entry %0d)", c, observe(), e, ok);
      end
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (observe() !== 3'b000) begin
      tests_failed++;
      $display("FAIL midrst_immediate: got %b required 000", observe());
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step(e, ok);
      tests_run++;
      if (!ok || observe() !== e || debouncer_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL midrst_after[%0d]: got %b required %b (entry %0d)", c, observe(), e, ok);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_noisy_rise();
    test_glitch_high();
    test_noisy_fall();
    test_glitch_low();
    test_boundary_hold();
    test_edge_pulse();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: got timeout at %0t required completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
